conv_window_gen: RTL and testbench

Streaming 5x5 window generator that sits directly upstream of the 5x5 convolution stage. It accepts 8-bit pixels in raster order and keeps the last four image rows in line buffers. For every fully interior pixel position it presents a packed 200-bit neighbourhood and runs one start/ready transaction with the convolution stage. The window is held stable for the whole transaction, because the convolution stage multiplies its inputs combinationally across several cycles.

---
 rtl/conv_window_gen_pkg.sv | 10 +
 rtl/conv_window_gen_if.sv | 14 +
 rtl/conv_window_gen_line_buffer.sv | 13 +
 rtl/conv_window_gen.sv | 67 ++++++
 tb/tb_conv_window_gen.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_gen_pkg.sv
// conv_pkg: shared window geometry, FSM state type and window-element bit offset
package conv_pkg;
  localparam int WIN = 5;
  localparam int PIX_W = 8;
  localparam int WIN_BITS = WIN * WIN * PIX_W;
  typedef enum logic [1:0] {COLLECT, ISSUE, ACK, BUSY} state_t;
  function automatic int el_off(int r, int c);
    return WIN_BITS - 1 - PIX_W * (WIN * r + c);
  endfunction
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel stream in (pix_in/pix_valid/pix_ready), window out (win_out/ctr_row/ctr_col/frame_done), conv handshake (conv_start/conv_ready)
interface conv_window_gen_if import conv_pkg::*; #(parameter int IMG_W = 16, parameter int IMG_H = 16);
  logic [PIX_W-1:0] pix_in;
  logic pix_valid;
  logic pix_ready;
  logic [WIN_BITS-1:0] win_out;
  logic conv_start;
  logic conv_ready;
  logic [$clog2(IMG_H)-1:0] ctr_row;
  logic [$clog2(IMG_W)-1:0] ctr_col;
  logic frame_done;
  modport master (output pix_in, pix_valid, conv_ready, input pix_ready, win_out, conv_start, ctr_row, ctr_col, frame_done);
  modport slave (input pix_in, pix_valid, conv_ready, output pix_ready, win_out, conv_start, ctr_row, ctr_col, frame_done);
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: one image row of pixels; clk, we, addr, wdata in, rdata out (read-before-write, RAM-inferable)
module line_buffer import conv_pkg::*; #(parameter int IMG_W = 16) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [IMG_W];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: 5x5 raster window generator; clk, rst (async high), bus = pixel stream in, window + conv start/ready handshake out
module conv_window_gen import conv_pkg::*; #(parameter int IMG_W = 16, parameter int IMG_H = 16) (
  input logic clk,
  input logic rst,
  conv_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t state, nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PIX_W-1:0] cv [WIN];
  logic [WIN_BITS-1:0] win_nxt;
  logic acc, last_col, last_row, win_ok;
  assign acc = bus.pix_valid & bus.pix_ready;
  assign last_col = col == CW'(IMG_W - 1);
  assign last_row = row == RW'(IMG_H - 1);
  assign win_ok = row >= RW'(4) && col >= CW'(4);
  assign cv[WIN-1] = bus.pix_in;
  // cv[i] is line buffer i at col (oldest row first); each buffer takes the next-younger row
  for (genvar i = 0; i < WIN - 1; i++) begin : g_lb
    line_buffer #(.IMG_W(IMG_W)) u_lb (
      .clk(clk),
      .we(acc),
      .addr(col),
      .wdata(cv[i+1]),
      .rdata(cv[i])
    );
  end
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < WIN; r++)
      win_nxt[el_off(r, 0) -: WIN*PIX_W] = {bus.win_out[el_off(r, 1) -: (WIN-1)*PIX_W], cv[r]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row <= '0;
      col <= '0;
      bus.win_out <= '0;
      bus.ctr_row <= '0;
      bus.ctr_col <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= acc & last_col & last_row;
      if (acc) begin
        bus.win_out <= win_nxt;
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? (last_row ? '0 : row + 1'b1) : row;
        if (win_ok) begin
          bus.ctr_row <= row - RW'(2);
          bus.ctr_col <= col - CW'(2);
        end
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= COLLECT;
    else state <= nxt;
  always_comb begin
    nxt = state;
    bus.pix_ready = state == COLLECT;
    bus.conv_start = state == ISSUE;
    nxt = state == COLLECT ? (acc && win_ok ? ISSUE : COLLECT) :
          state == ISSUE   ? ACK :
          state == ACK     ? (bus.conv_ready ? ACK : BUSY) :
                             (bus.conv_ready ? COLLECT : BUSY);
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: self-checking bench with a latency-configurable convolution model and an image-level window reference
module tb_conv_window_gen;
  import conv_pkg::*;
  localparam int W = 8;
  localparam int H = 8;
  typedef struct {logic [WIN_BITS-1:0] w; int cr; int cc; int idx;} win_t;
  typedef struct {int k; int cr; int cc; int e00; int e44;} tv_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  conv_window_gen_if #(.IMG_W(W), .IMG_H(H)) bus();
  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int lat = 14;
  int cnt;
  int last_idx = -1;
  logic [PIX_W-1:0] img [H][W];
  win_t expq [$];
  // convolution stage: captures start, drops ready next cycle, raises it after lat cycles
  always @(posedge clk or posedge rst)
    if (rst) begin
      bus.conv_ready <= 1'b1;
      cnt <= 0;
    end else if (bus.conv_start && bus.conv_ready) begin
      bus.conv_ready <= 1'b0;
      cnt <= lat;
    end else if (!bus.conv_ready) begin
      if (cnt <= 1) bus.conv_ready <= 1'b1;
      else cnt <= cnt - 1;
    end
  logic [WIN_BITS-1:0] o_win [512];
  int o_cr [512];
  int o_cc [512];
  int o_idx [512];
  int o_n = 0;
  int stab_bad = 0, pulse_bad = 0, dead_bad = 0, fd_cnt = 0, fd_bad = 0, hi_cnt = 0;
  logic [WIN_BITS-1:0] hold = '0;
  logic prev_start = 1'b0, prev_ready = 1'b1, seen_low = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.conv_start) begin
        o_win[o_n] <= bus.win_out;
        o_cr[o_n] <= int'(bus.ctr_row);
        o_cc[o_n] <= int'(bus.ctr_col);
        o_idx[o_n] <= last_idx;
        o_n <= o_n + 1;
        hold <= bus.win_out;
        if (prev_start) pulse_bad <= pulse_bad + 1;
      end
      if (!bus.pix_ready && !bus.conv_start && bus.win_out !== hold) stab_bad <= stab_bad + 1;
      if (!bus.pix_ready && !bus.conv_ready) seen_low <= 1'b1;
      if (!bus.pix_ready && bus.conv_ready && seen_low) hi_cnt <= hi_cnt + 1;
      if (bus.pix_ready && !prev_ready) begin
        if (hi_cnt != 1) dead_bad <= dead_bad + 1;
        hi_cnt <= 0;
        seen_low <= 1'b0;
      end
      if (bus.frame_done) begin
        fd_cnt <= fd_cnt + 1;
        if (last_idx != W*H-1 || !bus.conv_start) fd_bad <= fd_bad + 1;
      end
    end else begin
      hi_cnt <= 0;
      seen_low <= 1'b0;
    end
    prev_start <= bus.conv_start;
    prev_ready <= bus.pix_ready;
  end
  task automatic chk(string nm, logic [WIN_BITS-1:0] act, logic [WIN_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic build_expect(int n);
    win_t e;
    expq.delete();
    for (int r = 4; r < H; r++)
      for (int c = 4; c < W; c++)
        if (r*W + c < n) begin
          e.w = '0;
          for (int wr = 0; wr < WIN; wr++)
            for (int wc = 0; wc < WIN; wc++)
              e.w[WIN_BITS-1-PIX_W*(WIN*wr+wc) -: PIX_W] = img[r-4+wr][c-4+wc];
          e.cr = r - 2;
          e.cc = c - 2;
          e.idx = r*W + c;
          expq.push_back(e);
        end
  endtask
  task automatic send(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bit a = 1'b0;
      while (!a) begin
        @(negedge clk);
        bus.pix_in = img[i/W][i%W];
        bus.pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        a = bus.pix_valid && bus.pix_ready;
        @(posedge clk);
        t++;
        if (!a && t > 400) begin
          chk($sformatf("accept_timeout_pix%0d", i), 0, 1);
          @(negedge clk);
          bus.pix_valid = 1'b0;
          return;
        end
      end
      last_idx = i;
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask
  int base = 0, sb0 = 0, pb0 = 0, db0 = 0, fc0 = 0, fb0 = 0;
  task automatic check_frame(string nm, int fd_exp, bit wait_idle);
    int t = 0;
    int ne;
    if (wait_idle) begin
      do begin
        @(negedge clk);
        t++;
      end while (!(bus.pix_ready && bus.conv_ready) && t < 2000);
      chk({nm, "_idle_timeout"}, t < 2000, 1);
      repeat (3) @(negedge clk);
    end
    ne = expq.size();
    chk({nm, "_num_windows"}, o_n - base, ne);
    for (int k = 0; k < ne && base + k < o_n; k++) begin
      chk($sformatf("%s_win%0d", nm, k), o_win[base+k], expq[k].w);
      chk($sformatf("%s_ctr_row%0d", nm, k), o_cr[base+k], expq[k].cr);
      chk($sformatf("%s_ctr_col%0d", nm, k), o_cc[base+k], expq[k].cc);
      chk($sformatf("%s_issue_pix%0d", nm, k), o_idx[base+k], expq[k].idx);
    end
    chk({nm, "_win_stable"}, stab_bad - sb0, 0);
    chk({nm, "_start_one_cycle"}, pulse_bad - pb0, 0);
    chk({nm, "_ready_dead_cycle"}, dead_bad - db0, 0);
    chk({nm, "_frame_done_count"}, fd_cnt - fc0, fd_exp);
    chk({nm, "_frame_done_timing"}, fd_bad - fb0, 0);
    base = o_n;
    sb0 = stab_bad;
    pb0 = pulse_bad;
    db0 = dead_bad;
    fc0 = fd_cnt;
    fb0 = fd_bad;
  endtask
  task automatic ramp_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = PIX_W'(W*r + c);
  endtask
  tv_t tv [5];
  initial begin
    int f0;
    int t;
    logic [WIN_BITS-1:0] w;
    tv[0] = '{0, 2, 2, 0, 36};
    tv[1] = '{3, 2, 5, 3, 39};
    tv[2] = '{4, 3, 2, 8, 44};
    tv[3] = '{7, 3, 5, 11, 47};
    tv[4] = '{15, 5, 5, 27, 63};
    bus.pix_in = '0;
    bus.pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_pix_ready", bus.pix_ready, 1);
    chk("reset_conv_start", bus.conv_start, 0);
    chk("reset_frame_done", bus.frame_done, 0);
    chk("reset_win_out", bus.win_out, 0);
    chk("reset_ctr_row", bus.ctr_row, 0);
    chk("reset_ctr_col", bus.ctr_col, 0);
    rst = 1'b0;
    ramp_img();
    build_expect(W*H);
    f0 = base;
    send(W*H, 1'b0);
    check_frame("ramp0", 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w = o_win[f0 + tv[i].k];
      chk($sformatf("tab%0d_ctr_row", i), o_cr[f0 + tv[i].k], tv[i].cr);
      chk($sformatf("tab%0d_ctr_col", i), o_cc[f0 + tv[i].k], tv[i].cc);
      chk($sformatf("tab%0d_e00", i), w[WIN_BITS-1 -: PIX_W], tv[i].e00);
      chk($sformatf("tab%0d_e44", i), w[PIX_W-1:0], tv[i].e44);
    end
    send(W*H, 1'b0);
    check_frame("ramp1", 1, 1'b1);
    build_expect(45);
    send(45, 1'b0);
    t = 0;
    while (!(!bus.pix_ready && !bus.conv_ready && !bus.conv_start) && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("busy_reached", !bus.pix_ready && !bus.conv_ready && t < 200, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_pix_ready", bus.pix_ready, 1);
    chk("midrst_conv_start", bus.conv_start, 0);
    chk("midrst_win_out", bus.win_out, 0);
    chk("midrst_ctr", {bus.ctr_row, bus.ctr_col}, 0);
    chk("midrst_frame_done", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    check_frame("partial", 0, 1'b0);
    build_expect(W*H);
    send(W*H, 1'b0);
    check_frame("restart", 1, 1'b1);
    lat = int'($urandom_range(1, 20));
    send(W*H, 1'b1);
    check_frame("ramp_rndvalid", 1, 1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = PIX_W'($urandom);
      lat = int'($urandom_range(1, 20));
      build_expect(W*H);
      send(W*H, f != 1);
      check_frame($sformatf("rnd%0d", f), 1, 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
